// File: rtl/demux6_tdm_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux6_tdm_if
//  Description : Bus bundle for the 1-to-N TDM demultiplexer. The master
//                side supplies the data word and its steering controls. The
//                slave side returns the channel registers and status pulses.
//  Revision    : 1.0  initial release
// ============================================================================
interface demux6_tdm_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 6
);
   logic [WIDTH-1:0]     din;
   logic                 din_valid;
   logic                 mode;
   logic [2:0]           S;
   logic                 sync;
   logic [NCH*WIDTH-1:0] ch_data;
   logic [NCH-1:0]       ch_strobe;
   logic [2:0]           cur_slot;
   logic                 frame_done;
   logic                 err_sel;

   modport master (
      output din, din_valid, mode, S, sync,
      input  ch_data, ch_strobe, cur_slot, frame_done, err_sel
   );

   modport slave (
      input  din, din_valid, mode, S, sync,
      output ch_data, ch_strobe, cur_slot, frame_done, err_sel
   );
endinterface
`default_nettype wire

// File: rtl/demux6_tdm.sv
`default_nettype none
// ============================================================================
//  Module      : demux6_tdm
//  Description : Registered 1-to-NCH time-division demultiplexer. Each
//                accepted word is steered into one held channel register.
//                The channel comes from a wrapping slot counter (auto mode)
//                or from the external select S (direct mode). Per-channel
//                strobes, a frame-complete pulse and an illegal-select pulse
//                are also produced.
//  Revision    : 1.0  initial release
// ============================================================================
module demux6_tdm #(
   parameter int WIDTH = 8,
   parameter int NCH   = 6
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   demux6_tdm_if.slave   bus
);
   localparam logic [3:0] c_nch  = 4'(NCH);
   localparam logic [2:0] c_last = 3'(NCH - 1);

   logic [2:0]     r_slot;
   logic [NCH-1:0] r_strobe;
   logic           r_frame_done;
   logic           r_err_sel;

   logic [2:0]     w_slot_base;
   logic [2:0]     w_slot_nxt;
   logic [2:0]     w_target;
   logic           w_legal;
   logic           w_wr;
   logic           w_err;
   logic           w_frame;
   logic [NCH-1:0] w_wr_en;

   // Steering decode: sync realigns the counter before the target is chosen
   always_comb begin
      w_slot_base = bus.sync ? 3'd0 : r_slot;
      w_legal     = ({1'b0, bus.S} < c_nch);
      w_target    = bus.mode ? bus.S : w_slot_base;
      w_wr        = bus.din_valid & (~bus.mode | w_legal);
      w_err       = bus.din_valid & bus.mode & ~w_legal;
      w_frame     = bus.din_valid & ~bus.mode & (w_slot_base == c_last);
      w_slot_nxt  = w_slot_base;
      if (!bus.mode && bus.din_valid) begin
         w_slot_nxt = (w_slot_base == c_last) ? 3'd0 : w_slot_base + 3'd1;
      end
   end

   // Slot counter and single-cycle status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot       <= 3'd0;
         r_strobe     <= '0;
         r_frame_done <= 1'b0;
         r_err_sel    <= 1'b0;
      end else begin
         r_slot       <= w_slot_nxt;
         r_strobe     <= w_wr_en;
         r_frame_done <= w_frame;
         r_err_sel    <= w_err;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [WIDTH-1:0] r_ch;

      assign w_wr_en[k] = w_wr & (w_target == 3'(k));

      // Channel holding register, loaded only when this channel is targeted
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_ch <= '0;
         end else if (w_wr_en[k]) begin
            r_ch <= bus.din;
         end
      end

      assign bus.ch_data[k*WIDTH +: WIDTH] = r_ch;
   end

   assign bus.ch_strobe  = r_strobe;
   assign bus.cur_slot   = r_slot;
   assign bus.frame_done = r_frame_done;
   assign bus.err_sel    = r_err_sel;
endmodule
`default_nettype wire

// File: tb/tb_demux6_tdm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux6_tdm
//  Description : Directed self-checking bench for demux6_tdm.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux6_tdm;
   localparam int WIDTH = 8;
   localparam int NCH   = 6;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;
   logic [7:0] exp_ch [0:NCH-1];

   demux6_tdm_if #(.WIDTH(WIDTH), .NCH(NCH)) ifc ();

   demux6_tdm #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] chv(input int k);
      return ifc.ch_data[k*WIDTH +: WIDTH];
   endfunction

   // Drive one cycle of inputs, then sample 1 time unit after the edge
   task automatic step(input logic v, input logic [7:0] d, input logic m,
                       input logic [2:0] s, input logic sy);
      ifc.din_valid = v;
      ifc.din       = d;
      ifc.mode      = m;
      ifc.S         = s;
      ifc.sync      = sy;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      ifc.din_valid = 1'b1; ifc.din = 8'hEE; ifc.mode = 1'b0;
      ifc.S = 3'd0; ifc.sync = 1'b0;
      for (int k = 0; k < NCH; k++) exp_ch[k] = 8'h00;
      @(posedge clk); #3;
      total++;
      if (ifc.ch_data !== 48'h0) $display("FAIL reset_ch_data got %h exp 0", ifc.ch_data);
      else passed++;
      total++;
      if ({ifc.ch_strobe, ifc.cur_slot, ifc.frame_done, ifc.err_sel} !== 11'h0)
         $display("FAIL reset_status got strobe=%b slot=%0d fd=%b err=%b exp all 0",
                  ifc.ch_strobe, ifc.cur_slot, ifc.frame_done, ifc.err_sel);
      else passed++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      total++;
      if (ifc.ch_strobe !== 6'b0 || ifc.cur_slot !== 3'd0)
         $display("FAIL reset_release got strobe=%b slot=%0d exp 0/0", ifc.ch_strobe, ifc.cur_slot);
      else passed++;
   endtask

   task automatic test_auto_stream;
      for (int k = 0; k < NCH; k++) begin
         step(1'b1, 8'(8'h10 + k), 1'b0, 3'd0, 1'b0);
         exp_ch[k] = 8'(8'h10 + k);
         total++;
         if (ifc.ch_strobe !== 6'(1 << k))
            $display("FAIL auto_strobe%0d got %b exp %b", k, ifc.ch_strobe, 6'(1 << k));
         else passed++;
         total++;
         if (ifc.frame_done !== (k == NCH - 1))
            $display("FAIL auto_frame_done%0d got %b exp %b", k, ifc.frame_done, (k == NCH - 1));
         else passed++;
      end
      step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      total++;
      if (ifc.cur_slot !== 3'd0) $display("FAIL auto_wrap_slot got %0d exp 0", ifc.cur_slot);
      else passed++;
      total++;
      if (ifc.frame_done !== 1'b0 || ifc.ch_strobe !== 6'b0)
         $display("FAIL auto_idle_pulses got fd=%b strobe=%b exp 0", ifc.frame_done, ifc.ch_strobe);
      else passed++;
      for (int k = 0; k < NCH; k++) begin
         total++;
         if (chv(k) !== exp_ch[k]) $display("FAIL auto_ch%0d got %h exp %h", k, chv(k), exp_ch[k]);
         else passed++;
      end
   endtask

   task automatic test_auto_gaps;
      logic       v_pat [0:3];
      logic [7:0] d_pat [0:3];
      v_pat[0] = 1'b1; v_pat[1] = 1'b0; v_pat[2] = 1'b0; v_pat[3] = 1'b1;
      d_pat[0] = 8'hA1; d_pat[1] = 8'h5A; d_pat[2] = 8'h5B; d_pat[3] = 8'hA2;
      for (int i = 0; i < 4; i++) begin
         step(v_pat[i], d_pat[i], 1'b0, 3'd0, 1'b0);
         total++;
         if (ifc.ch_strobe !== ((i == 0) ? 6'b000001 : (i == 3) ? 6'b000010 : 6'b000000))
            $display("FAIL gap_strobe%0d got %b", i, ifc.ch_strobe);
         else passed++;
      end
      exp_ch[0] = 8'hA1; exp_ch[1] = 8'hA2;
      total++;
      if (chv(0) !== 8'hA1 || chv(1) !== 8'hA2)
         $display("FAIL gap_data got ch0=%h ch1=%h exp a1/a2", chv(0), chv(1));
      else passed++;
      total++;
      if (ifc.cur_slot !== 3'd2) $display("FAIL gap_slot got %0d exp 2", ifc.cur_slot);
      else passed++;
   endtask

   task automatic test_direct;
      logic [2:0] s_pat [0:2];
      logic [7:0] d_pat [0:2];
      s_pat[0] = 3'd5; s_pat[1] = 3'd0; s_pat[2] = 3'd3;
      d_pat[0] = 8'h55; d_pat[1] = 8'h00; d_pat[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, d_pat[i], 1'b1, s_pat[i], 1'b0);
         exp_ch[s_pat[i]] = d_pat[i];
         total++;
         if (ifc.ch_strobe !== 6'(1 << s_pat[i]))
            $display("FAIL direct_strobe%0d got %b exp %b", i, ifc.ch_strobe, 6'(1 << s_pat[i]));
         else passed++;
         total++;
         if (chv(int'(s_pat[i])) !== d_pat[i])
            $display("FAIL direct_data%0d got %h exp %h", i, chv(int'(s_pat[i])), d_pat[i]);
         else passed++;
      end
      total++;
      if (ifc.cur_slot !== 3'd2 || ifc.frame_done !== 1'b0)
         $display("FAIL direct_slot got slot=%0d fd=%b exp 2/0", ifc.cur_slot, ifc.frame_done);
      else passed++;
   endtask

   task automatic test_illegal_select;
      for (int s = 6; s < 8; s++) begin
         step(1'b1, 8'hFF, 1'b1, 3'(s), 1'b0);
         total++;
         if (ifc.err_sel !== 1'b1 || ifc.ch_strobe !== 6'b0)
            $display("FAIL illegal_pulse%0d got err=%b strobe=%b exp 1/0", s, ifc.err_sel, ifc.ch_strobe);
         else passed++;
      end
      step(1'b0, 8'hFF, 1'b1, 3'd6, 1'b0);
      total++;
      if (ifc.err_sel !== 1'b0) $display("FAIL illegal_single got err=%b exp 0", ifc.err_sel);
      else passed++;
      for (int k = 0; k < NCH; k++) begin
         total++;
         if (chv(k) !== exp_ch[k]) $display("FAIL illegal_ch%0d got %h exp %h", k, chv(k), exp_ch[k]);
         else passed++;
      end
   endtask

   task automatic test_sync;
      step(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
      total++;
      if (ifc.cur_slot !== 3'd0) $display("FAIL sync_idle_slot got %0d exp 0", ifc.cur_slot);
      else passed++;
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 8'(8'h31 + k), 1'b0, 3'd0, 1'b0);
         exp_ch[k] = 8'(8'h31 + k);
      end
      total++;
      if (ifc.cur_slot !== 3'd3) $display("FAIL sync_pre_slot got %0d exp 3", ifc.cur_slot);
      else passed++;
      step(1'b1, 8'h77, 1'b0, 3'd0, 1'b1);
      exp_ch[0] = 8'h77;
      total++;
      if (chv(0) !== 8'h77 || chv(3) !== exp_ch[3])
         $display("FAIL sync_write got ch0=%h ch3=%h exp 77/%h", chv(0), chv(3), exp_ch[3]);
      else passed++;
      total++;
      if (ifc.cur_slot !== 3'd1 || ifc.frame_done !== 1'b0 || ifc.ch_strobe !== 6'b000001)
         $display("FAIL sync_status got slot=%0d fd=%b strobe=%b exp 1/0/000001",
                  ifc.cur_slot, ifc.frame_done, ifc.ch_strobe);
      else passed++;
      // Direct-mode sync zeroes the counter while the write follows S
      step(1'b1, 8'h22, 1'b1, 3'd2, 1'b1);
      exp_ch[2] = 8'h22;
      total++;
      if (ifc.cur_slot !== 3'd0 || chv(2) !== 8'h22 || ifc.ch_strobe !== 6'b000100)
         $display("FAIL sync_direct got slot=%0d ch2=%h strobe=%b exp 0/22/000100",
                  ifc.cur_slot, chv(2), ifc.ch_strobe);
      else passed++;
      // Back in auto mode, writing resumes at the counter value
      step(1'b1, 8'h40, 1'b0, 3'd5, 1'b0);
      exp_ch[0] = 8'h40;
      total++;
      if (chv(0) !== 8'h40 || ifc.cur_slot !== 3'd1)
         $display("FAIL resume_auto got ch0=%h slot=%0d exp 40/1", chv(0), ifc.cur_slot);
      else passed++;
   endtask

   task automatic test_async_reset;
      for (int k = 1; k < 4; k++) step(1'b1, 8'(8'h60 + k), 1'b0, 3'd0, 1'b0);
      total++;
      if (ifc.cur_slot !== 3'd4) $display("FAIL areset_pre_slot got %0d exp 4", ifc.cur_slot);
      else passed++;
      ifc.din_valid = 1'b1; ifc.din = 8'hBB;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (ifc.ch_data !== 48'h0 || ifc.cur_slot !== 3'd0 || ifc.ch_strobe !== 6'b0)
         $display("FAIL areset_immediate got data=%h slot=%0d strobe=%b exp 0",
                  ifc.ch_data, ifc.cur_slot, ifc.ch_strobe);
      else passed++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      total++;
      if (ifc.ch_strobe !== 6'b0 || ifc.ch_data !== 48'h0)
         $display("FAIL areset_quiet got strobe=%b data=%h exp 0", ifc.ch_strobe, ifc.ch_data);
      else passed++;
      step(1'b1, 8'h99, 1'b0, 3'd0, 1'b0);
      total++;
      if (chv(0) !== 8'h99 || ifc.ch_strobe !== 6'b000001 || ifc.cur_slot !== 3'd1)
         $display("FAIL areset_first_word got ch0=%h strobe=%b slot=%0d exp 99/000001/1",
                  chv(0), ifc.ch_strobe, ifc.cur_slot);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_auto_stream();
      test_auto_gaps();
      test_direct();
      test_illegal_select();
      test_sync();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/demux6_tdm.md
Name: demux6_tdm

Overview:
Registered 1-to-6 time-division demultiplexer, the distribution side of the team's 6-input select mux. It takes one shared data word per cycle and steers it into one of six held channel registers. The channel is chosen either by an internal wrapping slot counter (auto mode) or by an external 3-bit select S, using the same encoding as the mux (S=000 -> channel 0 ... S=101 -> channel 5). It sits after a serial/TDM link and feeds per-channel consumers with update strobes and a frame-complete pulse.

Parameters:
WIDTH, 8, data width of din and of each channel register
NCH, 6, number of channels; legal range 2..8; slot/select width fixed at 3 bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
din  input  WIDTH  shared input data word
din_valid  input  1  din is accepted this cycle when high
mode  input  1  0 = auto (slot counter selects), 1 = direct (S selects)
S  input  3  direct-mode channel select, same encoding as the 6-input mux
sync  input  1  frame realign: forces slot counter to channel 0
ch_data  output  NCH*WIDTH  channel registers, channel k at bits [k*WIDTH +: WIDTH]
ch_strobe  output  NCH  one-cycle pulse, bit k high the cycle after channel k is written
cur_slot  output  3  slot counter value (next channel to be written in auto mode)
frame_done  output  1  one-cycle pulse after channel NCH-1 is written in auto mode
err_sel  output  1  one-cycle pulse after a direct-mode write with S >= NCH

Behaviour:
- Reset (rst_n low, asynchronous): ch_data all 0, ch_strobe 0, cur_slot 0, frame_done 0, err_sel 0. Release is synchronous to the next clk edge; no write occurs on the edge where rst_n is still low.
- All outputs are registered. Write latency is 1 cycle: din accepted at edge N appears on ch_data and is strobed in the cycle after edge N.
- Unwritten channels hold their value indefinitely. ch_strobe, frame_done and err_sel are single-cycle pulses and are 0 on any cycle with no qualifying write.
- Auto mode (mode=0):
  - Target channel = cur_slot.
  - On din_valid: write the target channel, pulse its strobe, advance cur_slot by 1.
  - Wrap: NCH-1 -> 0. The write to channel NCH-1 also pulses frame_done in the following cycle.
  - With din_valid low, cur_slot holds.
- Direct mode (mode=1):
  - Target channel = S.
  - On din_valid with S < NCH: write channel S and pulse ch_strobe[S].
  - On din_valid with S >= NCH (110 or 111 when NCH=6): drop the word; no channel changes, no strobe, err_sel pulses.
  - cur_slot is frozen in direct mode. frame_done never pulses in direct mode.
- sync, auto mode:
  - sync without din_valid: cur_slot <= 0.
  - sync with din_valid: the word goes to channel 0 and cur_slot <= 1 (sync overrides the current counter value before target selection).
  - If NCH=... frame_done rules are unchanged; a sync in the middle of a frame does not pulse frame_done.
- sync, direct mode: cur_slot <= 0; the write still follows S.
- Mode switching takes effect on the same cycle. Direct-mode activity never disturbs cur_slot except through sync. On return to auto mode, writing resumes at the frozen cur_slot.
- cur_slot is always in the range 0..NCH-1.
- Simultaneous events: reset has highest priority, then sync, then din_valid.

Test Plan:
- Reset then auto stream: mode=0, six valid words 0x10..0x15 -> ch_data[k]=0x10+k, ch_strobe walks bit0..bit5 one per cycle, frame_done high only in the cycle after 0x15, cur_slot back to 0.
- Auto with gaps: din_valid pattern 1,0,0,1 with words 0xA1, 0xA2 -> ch0=0xA1, ch1=0xA2, cur_slot=2, no strobes during the gap cycles.
- Direct mode sweep: mode=1, S=5 din=0x55, S=0 din=0x00, S=3 din=0x33 -> ch5=0x55, ch0=0x00, ch3=0x33, strobes 6'b100000 then 6'b000001 then 6'b001000, cur_slot unchanged.
- Illegal select: mode=1, S=3'b110 din=0xFF -> err_sel single pulse, all ch_data unchanged, ch_strobe=0.
- Mid-frame sync: auto mode with 3 words written (cur_slot=3), then sync together with din_valid and din=0x77 -> ch0=0x77, cur_slot=1, no frame_done pulse.
- Async reset mid-stream: assert rst_n low between clock edges while cur_slot=4 -> all outputs 0 immediately, no strobe after release until the next valid word, which lands in ch0.
